fifo_to_sdram_writer: RTL

Upload-side counterpart of the VGA read path. Drains 8-bit pixels from a show-ahead byte FIFO (filled by the host link) and packs byte pairs into 16-bit words, upper byte first. Writes one full frame into SDRAM through the Avalon-MM write port. Uses the same {frame, line, word} address map the display reader consumes.

---
 rtl/fifo_to_sdram_writer_pkg.sv | 24 ++
 rtl/fifo_to_sdram_writer_addr_counter.sv | 47 ++++
 rtl/fifo_to_sdram_writer.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/fifo_to_sdram_writer_pkg.sv
// SDRAM frame-buffer address map shared by the upload writer and the display reader.
package fifo_to_sdram_writer_pkg;

    localparam int FRAME_W   = 6;
    localparam int LINE_W    = 10;
    localparam int WORD_W    = 9;
    localparam int ADDR_W    = FRAME_W + LINE_W + WORD_W;

    localparam int WORD_LSB  = 0;
    localparam int LINE_LSB  = WORD_LSB + WORD_W;
    localparam int FRAME_LSB = LINE_LSB + LINE_W;

    localparam int DEF_WORDS_PER_LINE  = 512;
    localparam int DEF_LINES_PER_FRAME = 1024;

    function automatic logic [ADDR_W-1:0] make_sdram_addr(
        input logic [FRAME_W-1:0] frame,
        input logic [LINE_W-1:0]  line,
        input logic [WORD_W-1:0]  word
    );
        return {frame, line, word};
    endfunction

endpackage

// File: rtl/fifo_to_sdram_writer_addr_counter.sv
// Line/word position counter over one frame; o_last flags the final word of the frame.
module fifo_to_sdram_writer_addr_counter
    import fifo_to_sdram_writer_pkg::*;
#(
    parameter int WORDS_PER_LINE  = DEF_WORDS_PER_LINE,
    parameter int LINES_PER_FRAME = DEF_LINES_PER_FRAME
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_clear,
    input  logic              i_advance,
    output logic [WORD_W-1:0] o_word,
    output logic [LINE_W-1:0] o_line,
    output logic              o_last
);

    localparam logic [WORD_W-1:0] LP_WORD_LAST = WORD_W'(WORDS_PER_LINE - 1);
    localparam logic [LINE_W-1:0] LP_LINE_LAST = LINE_W'(LINES_PER_FRAME - 1);

    logic [WORD_W-1:0] r_word;
    logic [LINE_W-1:0] r_line;
    logic              w_line_end;

    assign w_line_end = (r_word == LP_WORD_LAST);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_word <= '0;
            r_line <= '0;
        end else if (i_clear) begin
            r_word <= '0;
            r_line <= '0;
        end else if (i_advance) begin
            if (w_line_end) begin
                r_word <= '0;
                r_line <= r_line + 1'b1;
            end else begin
                r_word <= r_word + 1'b1;
            end
        end
    end

    assign o_word = r_word;
    assign o_line = r_line;
    assign o_last = w_line_end && (r_line == LP_LINE_LAST);

endmodule

// File: rtl/fifo_to_sdram_writer.sv
// Packs byte pairs from a show-ahead FIFO into 16-bit words and writes one frame over Avalon-MM.
// Optional FRAME_CHECKSUM_EN adds oCHECKSUM, the mod-2^16 sum of the words written.
module fifo_to_sdram_writer
    import fifo_to_sdram_writer_pkg::*;
#(
    parameter int WORDS_PER_LINE  = DEF_WORDS_PER_LINE,
    parameter int LINES_PER_FRAME = DEF_LINES_PER_FRAME
) (
    input  logic               iCLK,
    input  logic               iRST_N,
    input  logic               iSTART,
    input  logic [FRAME_W-1:0] iFRAME_ID,
    input  logic               iABORT,
    output logic               oBUSY,
    output logic               oDONE,
    input  logic               iFIFO_EMPTY,
    input  logic [7:0]         iFIFO_RDATA,
    output logic               oFIFO_REN,
    input  logic               iWAIT_REQUEST,
    output logic               oWR_EN,
    output logic [ADDR_W-1:0]  oWR_ADDR,
    output logic [15:0]        oWR_DATA
`ifdef FRAME_CHECKSUM_EN
    ,
    output logic [15:0]        oCHECKSUM
`endif
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH_HI,
        S_FETCH_LO,
        S_WRITE,
        S_DONE
    } state_t;

    state_t             r_state;
    state_t             w_next_state;
    logic               w_pop;
    logic               w_start;
    logic               w_accept;
    logic               w_last;
    logic [WORD_W-1:0]  w_word;
    logic [LINE_W-1:0]  w_line;
    logic [FRAME_W-1:0] r_frame;
    logic [15:0]        r_data;

    assign w_start  = (r_state == S_IDLE) && iSTART && !iABORT;
    assign w_accept = (r_state == S_WRITE) && !iWAIT_REQUEST;

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // A pending Avalon write is never dropped: abort only takes effect once it is accepted.
    always_comb begin
        w_next_state = r_state;
        w_pop        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (iSTART && !iABORT) w_next_state = S_FETCH_HI;
            end
            S_FETCH_HI: begin
                if (iABORT) begin
                    w_next_state = S_IDLE;
                end else if (!iFIFO_EMPTY) begin
                    w_pop        = 1'b1;
                    w_next_state = S_FETCH_LO;
                end
            end
            S_FETCH_LO: begin
                if (iABORT) begin
                    w_next_state = S_IDLE;
                end else if (!iFIFO_EMPTY) begin
                    w_pop        = 1'b1;
                    w_next_state = S_WRITE;
                end
            end
            S_WRITE: begin
                if (!iWAIT_REQUEST) begin
                    if (iABORT)      w_next_state = S_IDLE;
                    else if (w_last) w_next_state = S_DONE;
                    else             w_next_state = S_FETCH_HI;
                end
            end
            S_DONE: begin
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            r_frame <= '0;
            r_data  <= '0;
        end else begin
            if (w_start) r_frame <= iFRAME_ID;
            if (w_pop && (r_state == S_FETCH_HI)) r_data[15:8] <= iFIFO_RDATA;
            if (w_pop && (r_state == S_FETCH_LO)) r_data[7:0]  <= iFIFO_RDATA;
        end
    end

    fifo_to_sdram_writer_addr_counter #(
        .WORDS_PER_LINE  (WORDS_PER_LINE),
        .LINES_PER_FRAME (LINES_PER_FRAME)
    ) u_addr_counter (
        .i_clk     (iCLK),
        .i_rst_n   (iRST_N),
        .i_clear   (w_start),
        .i_advance (w_accept),
        .o_word    (w_word),
        .o_line    (w_line),
        .o_last    (w_last)
    );

`ifdef FRAME_CHECKSUM_EN
    logic [15:0] r_checksum;

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            r_checksum <= '0;
        end else if (w_start) begin
            r_checksum <= '0;
        end else if (w_accept) begin
            r_checksum <= r_checksum + r_data;
        end
    end

    assign oCHECKSUM = r_checksum;
`endif

    assign oBUSY     = (r_state != S_IDLE);
    assign oDONE     = (r_state == S_DONE);
    assign oWR_EN    = (r_state == S_WRITE);
    assign oFIFO_REN = w_pop;
    assign oWR_ADDR  = make_sdram_addr(r_frame, w_line, w_word);
    assign oWR_DATA  = r_data;

endmodule
